// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART byte-stream program loader into instruction memory (optional checksum: IMEM_LOADER_CHECKSUM_EN)
module imem_loader #(
    parameter int                  len_data  = 32,
    parameter int                  ram_depth = 2048,
    parameter logic [len_data-1:0] halt_word = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_start,
    input  logic [7:0]          in_rx_data,
    input  logic                in_rx_done,
    output logic [len_data-1:0] out_addr_debug,
    output logic [len_data-1:0] out_ins_to_mem,
    output logic                out_wea_ram_inst,
    output logic                out_debug_flag,
    output logic                out_cpu_stall,
    output logic                out_load_done,
    output logic                out_overflow,
    output logic                out_checksum_err
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    localparam logic [len_data-1:0] LAST_ADDR = len_data'(ram_depth - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [len_data-1:0] r_addr;
    logic [len_data-1:0] r_word;
    logic [len_data-1:0] r_ins;
    logic [1:0]          r_byte_cnt;
    logic                r_wea;
    logic                r_eval;      // cycle after the write pulse: decide halt/overflow/advance
    logic                r_debug;
    logic                r_done;
    logic                r_overflow;
    logic [len_data-1:0] w_shift;
    logic                w_halt;
    logic                w_last;
    logic                w_ck_window;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_xor;
    logic [7:0]          r_ck_byte;
    logic                r_ck_have;   // checksum byte arrived before CHECK was entered
    logic                r_ck_err;
    logic [7:0]          w_ck_byte;

    // A byte arriving while the halt word is being written is the checksum byte
    assign w_ck_window = (r_wea || r_eval) && w_halt;
    assign w_ck_byte   = r_ck_have ? r_ck_byte : in_rx_data;
`else
    assign w_ck_window = 1'b0;
`endif

    assign w_shift = {r_word[len_data-9:0], in_rx_data};
    assign w_halt  = (r_ins == halt_word);
    assign w_last  = (r_addr == LAST_ADDR);

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (in_start) w_state_next = LOAD;
            end
            LOAD: begin
                if (r_eval) begin
                    if (w_halt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_state_next = CHECK;
`else
                        w_state_next = DONE;
`endif
                    end else if (w_last) begin
                        w_state_next = DONE;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (r_ck_have || in_rx_done) w_state_next = DONE;
            end
`endif
            default: w_state_next = r_state;
        endcase
    end

    // State register, byte assembly, write pulse, address and flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_word     <= '0;
            r_ins      <= '0;
            r_byte_cnt <= '0;
            r_wea      <= 1'b0;
            r_eval     <= 1'b0;
            r_debug    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= '0;
            r_ck_byte  <= '0;
            r_ck_have  <= 1'b0;
            r_ck_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_debug <= (w_state_next == LOAD) || (w_state_next == CHECK);
            r_done  <= (w_state_next == DONE);
            r_wea   <= 1'b0;
            r_eval  <= r_wea;
            case (r_state)
                IDLE, DONE: begin
                    if (in_start) begin
                        r_addr     <= '0;
                        r_word     <= '0;
                        r_byte_cnt <= '0;
                        r_overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor      <= '0;
                        r_ck_have  <= 1'b0;
                        r_ck_err   <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (in_rx_done && !w_ck_window) begin
                        r_word     <= w_shift;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor      <= r_xor ^ in_rx_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_ins <= w_shift;
                            r_wea <= 1'b1;
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (in_rx_done && w_ck_window) begin
                        r_ck_byte <= in_rx_data;
                        r_ck_have <= 1'b1;
                    end
`endif
                    // Overflow is judged on the current address, before any increment
                    if (r_eval && !w_halt) begin
                        if (w_last) r_overflow <= 1'b1;
                        else        r_addr     <= r_addr + len_data'(1);
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_state_next == DONE) r_ck_err <= (w_ck_byte != r_xor);
                end
`endif
                default: ;
            endcase
        end
    end

    assign out_addr_debug   = r_addr;
    assign out_ins_to_mem   = r_ins;
    assign out_wea_ram_inst = r_wea;
    assign out_debug_flag   = r_debug;
    assign out_cpu_stall    = r_debug;
    assign out_load_done    = r_done;
    assign out_overflow     = r_overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign out_checksum_err = r_ck_err;
`else
    assign out_checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (honours IMEM_LOADER_CHECKSUM_EN)
module tb_imem_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFFFFFF;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_start = 1'b0;
    logic [7:0]  in_rx_data = 8'h00;
    logic        in_rx_done = 1'b0;
    logic [31:0] out_addr_debug;
    logic [31:0] out_ins_to_mem;
    logic        out_wea_ram_inst;
    logic        out_debug_flag;
    logic        out_cpu_stall;
    logic        out_load_done;
    logic        out_overflow;
    logic        out_checksum_err;

    imem_loader #(.len_data(32), .ram_depth(DEPTH), .halt_word(HALT)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_start         (in_start),
        .in_rx_data       (in_rx_data),
        .in_rx_done       (in_rx_done),
        .out_addr_debug   (out_addr_debug),
        .out_ins_to_mem   (out_ins_to_mem),
        .out_wea_ram_inst (out_wea_ram_inst),
        .out_debug_flag   (out_debug_flag),
        .out_cpu_stall    (out_cpu_stall),
        .out_load_done    (out_load_done),
        .out_overflow     (out_overflow),
        .out_checksum_err (out_checksum_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];
    int          wr_cyc[$];
    int          strobe_cyc[$];
    logic [7:0]  prog[$];
    logic [63:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse is matched against the oldest expected write
    always @(negedge clk) begin
        if (reset && out_wea_ram_inst) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required=none", out_addr_debug, out_ins_to_mem);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", out_addr_debug, e[63:32]);
                check("write_data", out_ins_to_mem, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_rx_data = b;
        in_rx_done = 1'b1;
        @(posedge clk);
        #1;
        strobe_cyc.push_back(cyc);
        in_rx_done = 1'b0;
    endtask

    task automatic pulse_start();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    function automatic void add_word(input logic [31:0] w);
        prog.push_back(w[31:24]);
        prog.push_back(w[23:16]);
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
    endfunction

    // Reference: words fill addresses 0,1,.. until the halt word or the last address
    task automatic model(output bit ovf, output int last_addr, output logic [7:0] x);
        logic [31:0] w;
        ovf = 1'b0;
        last_addr = 0;
        x = 8'h00;
        for (int k = 0; k * 4 + 3 < prog.size(); k++) begin
            w = {prog[k*4], prog[k*4+1], prog[k*4+2], prog[k*4+3]};
            x = x ^ prog[k*4] ^ prog[k*4+1] ^ prog[k*4+2] ^ prog[k*4+3];
            exp_q.push_back({32'(k), w});
            last_addr = k;
            if (w == HALT) break;
            if (k == DEPTH - 1) begin
                ovf = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!out_load_done && n < 60) begin
            tick();
            n++;
        end
        check({name, "_done_reached"}, 32'(out_load_done), 32'd1);
    endtask

    task automatic do_load(input int gapmax, input bit bad_ck, input bit timing, input bit mid_start,
                           input string name);
        bit         ovf;
        int         la;
        logic [7:0] x;
        exp_q.delete();
        wr_cyc.delete();
        strobe_cyc.delete();
        model(ovf, la, x);
        pulse_start();
        check({name, "_start_addr"}, out_addr_debug, 32'd0);
        check({name, "_start_ovf"}, 32'(out_overflow), 32'd0);
        check({name, "_start_stall"}, 32'(out_cpu_stall), 32'd1);
        check({name, "_start_done"}, 32'(out_load_done), 32'd0);
        foreach (prog[i]) begin
            repeat ($urandom_range(0, gapmax)) tick();
            send(prog[i]);
            if (mid_start && i == 1) begin
                pulse_start();
                check({name, "_midstart_addr"}, out_addr_debug, 32'd0);
                check({name, "_midstart_flag"}, 32'(out_debug_flag), 32'd1);
            end
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (timing) begin
            check({name, "_halt_pulse"}, 32'(out_wea_ram_inst), 32'd1);
            tick();
            check({name, "_n1_done"}, 32'(out_load_done), 32'd0);
            check({name, "_n1_flag"}, 32'(out_debug_flag), 32'd1);
            tick();
            check({name, "_n2_done"}, 32'(out_load_done), 32'd1);
            check({name, "_n2_flag"}, 32'(out_debug_flag), 32'd0);
        end
`endif
        if (CK && !ovf) begin
            repeat ($urandom_range(0, 2)) tick();
            send(bad_ck ? (x ^ 8'($urandom_range(1, 255))) : x);
        end
        wait_done(name);
        tick();
        tick();
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_overflow"}, 32'(out_overflow), 32'(ovf));
        check({name, "_final_addr"}, out_addr_debug, 32'(la));
        check({name, "_ck_err"}, 32'(out_checksum_err), 32'(CK && !ovf && bad_ck));
        check({name, "_final_flag"}, 32'(out_debug_flag), 32'd0);
        check({name, "_final_stall"}, 32'(out_cpu_stall), 32'd0);
        check({name, "_final_done"}, 32'(out_load_done), 32'd1);
    endtask

    initial begin
        int          n;
        logic [31:0] w;
        repeat (3) tick();
        check("rst_addr", out_addr_debug, 32'd0);
        check("rst_ins", out_ins_to_mem, 32'd0);
        check("rst_wea", 32'(out_wea_ram_inst), 32'd0);
        check("rst_flag", 32'(out_debug_flag), 32'd0);
        check("rst_stall", 32'(out_cpu_stall), 32'd0);
        check("rst_done", 32'(out_load_done), 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        check("rst_ckerr", 32'(out_checksum_err), 32'd0);
        reset = 1'b1;
        tick();

        // Reset in the middle of a word, then a clean load must start at byte 0, addr 0
        pulse_start();
        send(8'hAA);
        send(8'hBB);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_flag", 32'(out_debug_flag), 32'd0);
        check("midrst_stall", 32'(out_cpu_stall), 32'd0);
        check("midrst_addr", out_addr_debug, 32'd0);
        check("midrst_done", 32'(out_load_done), 32'd0);
        reset = 1'b1;
        tick();

        prog.delete();
        add_word(32'h20010005);
        add_word(HALT);
        do_load(0, 1'b0, 1'b1, 1'b0, "basic");

        prog.delete();
        add_word(32'h01020304);
        add_word(32'h05060708);
        add_word(HALT);
        do_load(0, 1'b0, 1'b0, 1'b0, "b2b");
        check("b2b_nwrites", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() >= 2 && strobe_cyc.size() >= 1) begin
            check("b2b_pulse0_cycle", 32'(wr_cyc[0] - strobe_cyc[0]), 32'd3);
            check("b2b_pulse1_cycle", 32'(wr_cyc[1] - strobe_cyc[0]), 32'd7);
        end

        prog.delete();
        for (int k = 0; k < DEPTH; k++) add_word(32'h11111111 * (k + 1));
        do_load(1, 1'b0, 1'b0, 1'b0, "overflow");

        prog.delete();
        add_word(32'h11223344);
        add_word(HALT);
        do_load(1, 1'b0, 1'b0, 1'b1, "midstart");

        prog.delete();
        add_word(32'h00000001);
        add_word(HALT);
        do_load(1, 1'b0, 1'b0, 1'b0, "ck_good");
        do_load(1, 1'b1, 1'b0, 1'b0, "ck_bad");

        for (int it = 0; it < 20; it++) begin
            prog.delete();
            n = $urandom_range(0, DEPTH);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                if (w == HALT) w = w ^ 32'h1;
                add_word(w);
            end
            if (n < DEPTH) add_word(HALT);
            do_load($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
